// File: rtl/clock_pkg.sv
// Shared field widths, limits and FSM encoding for the clock register slice.
// The 12-hour limits are used when CLOCK_TWELVE_HOUR_EN is defined.
package clock_pkg;

    localparam int unsigned HOURS_W   = 5;
    localparam int unsigned MINUTES_W = 6;
    localparam int unsigned SECONDS_W = 6;

    localparam int unsigned SECONDS_MAX  = 59;
    localparam int unsigned MINUTES_MAX  = 59;
    localparam int unsigned HOURS_MAX_24 = 23;
    localparam int unsigned HOURS_MAX_12 = 12;

    // 11 -> 12 is where the meridiem flips in 12-hour mode
    localparam int unsigned HOURS_PM_FLIP = 11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_SET_HOURS,
        ST_SET_MINUTES
    } clock_state_e;

endpackage

// File: rtl/clock_field_counter.sv
// Mod-N field counter: counts MIN_VAL..MAX_VAL, clear loads RESET_VAL.
// wrap is combinational and flags an increment taken at MAX_VAL.
module clock_field_counter #(
    parameter int unsigned WIDTH     = 6,
    parameter int unsigned MIN_VAL   = 0,
    parameter int unsigned MAX_VAL   = 59,
    parameter int unsigned RESET_VAL = 0
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             inc,
    input  logic             clear,
    output logic [WIDTH-1:0] value,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] RST_V = WIDTH'(RESET_VAL);

    assign wrap = inc && (value == MAX_V);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            value <= RST_V;
        end else if (clear) begin
            value <= RST_V;
        end else if (inc) begin
            value <= (value == MAX_V) ? MIN_V : value + 1'b1;
        end
    end

endmodule

// File: rtl/clock_register.sv
// Time-of-day register with hour/minute set modes.
// Define CLOCK_TWELVE_HOUR_EN for 1..12 hours with a PM flag; default is 0..23.
module clock_register
    import clock_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_1hz_stb,
    input  logic                 i_slow_set_stb,
    input  logic                 i_fast_set_stb,
    input  logic                 i_fast_set,
    input  logic                 i_set_hours,
    input  logic                 i_set_minutes,
    output logic [HOURS_W-1:0]   o_hours,
    output logic [MINUTES_W-1:0] o_minutes,
    output logic [SECONDS_W-1:0] o_seconds,
    output logic                 o_pm
);

`ifdef CLOCK_TWELVE_HOUR_EN
    localparam int unsigned HR_MIN = 1;
    localparam int unsigned HR_MAX = HOURS_MAX_12;
    localparam int unsigned HR_RST = HOURS_MAX_12;
`else
    localparam int unsigned HR_MIN = 0;
    localparam int unsigned HR_MAX = HOURS_MAX_24;
    localparam int unsigned HR_RST = 0;
`endif

    clock_state_e state_q, state_d;

    logic set_stb;
    logic sec_inc, sec_clr, sec_wrap;
    logic min_inc, min_wrap;
    logic hr_inc, hr_wrap_unused;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = ST_RUN;
        if (i_set_hours) begin
            state_d = ST_SET_HOURS;
        end else if (i_set_minutes) begin
            state_d = ST_SET_MINUTES;
        end
    end

    assign set_stb = i_fast_set ? i_fast_set_stb : i_slow_set_stb;

    // Kept as separate assigns so the inc->wrap->inc ripple is not a false loop
    assign sec_clr = (state_q == ST_SET_MINUTES);
    assign sec_inc = (state_q != ST_SET_MINUTES) && i_1hz_stb;
    assign min_inc = (state_q == ST_SET_MINUTES) ? set_stb : sec_wrap;
    assign hr_inc  = (state_q == ST_SET_HOURS)   ? set_stb
                                                  : ((state_q == ST_RUN) && min_wrap);

    clock_field_counter #(
        .WIDTH    (SECONDS_W),
        .MIN_VAL  (0),
        .MAX_VAL  (SECONDS_MAX),
        .RESET_VAL(0)
    ) u_seconds (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .inc      (sec_inc),
        .clear    (sec_clr),
        .value    (o_seconds),
        .wrap     (sec_wrap)
    );

    clock_field_counter #(
        .WIDTH    (MINUTES_W),
        .MIN_VAL  (0),
        .MAX_VAL  (MINUTES_MAX),
        .RESET_VAL(0)
    ) u_minutes (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .inc      (min_inc),
        .clear    (1'b0),
        .value    (o_minutes),
        .wrap     (min_wrap)
    );

    clock_field_counter #(
        .WIDTH    (HOURS_W),
        .MIN_VAL  (HR_MIN),
        .MAX_VAL  (HR_MAX),
        .RESET_VAL(HR_RST)
    ) u_hours (
        .i_clk    (i_clk),
        .i_reset_n(i_reset_n),
        .inc      (hr_inc),
        .clear    (1'b0),
        .value    (o_hours),
        .wrap     (hr_wrap_unused)
    );

`ifdef CLOCK_TWELVE_HOUR_EN
    logic pm_q;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pm_q <= 1'b0;
        end else if (hr_inc && (o_hours == HOURS_W'(HOURS_PM_FLIP))) begin
            pm_q <= ~pm_q;
        end
    end

    assign o_pm = pm_q;
`else
    assign o_pm = 1'b0;
`endif

endmodule
